// File: rtl/lod_operand_stage.sv
// ---------------------------------------------------------------------------
// lod_operand_stage
//
// Operand-preparation stage feeding the 16-bit carry-select subtractor of the
// ImprLM datapath. For each of two operands (A, B) it finds the leading-one
// index k and the one-hot power p = 2^k. It then hands the operand value together
// with p to the subtractor, which forms the residue a - p.
//
// Pipeline: two register stages (S1 = raw operands, S2 = LOD results).
// Latency is 2 cycles and throughput is 1 transaction per cycle. Flow control is
// a valid/ready handshake with full backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   input transaction valid
//   in_ready   stage can accept an input this cycle
//   in_a/in_b  operands A and B
//   out_valid  output transaction valid
//   out_ready  downstream accepts the output
//   out_a      registered copy of A (minuend)
//   out_pa     2^kA one-hot (subtrahend), 0 when A == 0
//   out_ka     leading-one index of A (0 when A == 0)
//   out_za     A == 0
//   out_b, out_pb, out_kb, out_zb   same set for operand B
// ---------------------------------------------------------------------------
module lod_operand_stage #(
    parameter int WIDTH = 16,
    parameter int KW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_pa,
    output logic [KW-1:0]    out_ka,
    output logic             out_za,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_pb,
    output logic [KW-1:0]    out_kb,
    output logic             out_zb
);

    // Index of the highest set bit. The scan runs upward, so the last hit wins.
    // A zero operand falls through to index 0.
    function automatic logic [KW-1:0] lod_index(input logic [WIDTH-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                k = KW'(i);
            end
        end
        return k;
    endfunction

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_pa;
    logic [KW-1:0]    s2_ka;
    logic             s2_za;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH-1:0] s2_pb;
    logic [KW-1:0]    s2_kb;
    logic             s2_zb;

    logic             s1_en;
    logic             s2_en;
    logic             in_hs;

    logic [KW-1:0]    lod_ka;
    logic [KW-1:0]    lod_kb;
    logic             lod_za;
    logic             lod_zb;
    logic [WIDTH-1:0] lod_pa;
    logic [WIDTH-1:0] lod_pb;

    // A stage advances when it is empty or when the stage after it is moving.
    // As a result, in_ready drops only when both stages hold data and the
    // output is stalled.
    always_comb begin
        s2_en    = !s2_valid || out_ready;
        s1_en    = !s1_valid || s2_en;
        in_ready = s1_en;
        in_hs    = in_valid && s1_en;
    end

    // Leading-one detection on the S1 operands. A zero operand is forced to
    // p = 0. The subtractor then sees a - p = 0 and never a negative residue.
    always_comb begin
        lod_ka = lod_index(s1_a);
        lod_kb = lod_index(s1_b);
        lod_za = (s1_a == '0);
        lod_zb = (s1_b == '0);
        lod_pa = lod_za ? '0 : (ONE << lod_ka);
        lod_pb = lod_zb ? '0 : (ONE << lod_kb);
    end

    // Stage 1 holds the raw operands. Data loads only on a real handshake.
    // When S1 advances without a new input it becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_en) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_a <= in_a;
                s1_b <= in_b;
            end
        end
    end

    // Stage 2 holds the LOD results and drives the outputs directly. It keeps
    // its contents whenever the downstream stalls a valid result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_pa    <= '0;
            s2_ka    <= '0;
            s2_za    <= 1'b0;
            s2_b     <= '0;
            s2_pb    <= '0;
            s2_kb    <= '0;
            s2_zb    <= 1'b0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a  <= s1_a;
                s2_pa <= lod_pa;
                s2_ka <= lod_ka;
                s2_za <= lod_za;
                s2_b  <= s1_b;
                s2_pb <= lod_pb;
                s2_kb <= lod_kb;
                s2_zb <= lod_zb;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_a     = s2_a;
    assign out_pa    = s2_pa;
    assign out_ka    = s2_ka;
    assign out_za    = s2_za;
    assign out_b     = s2_b;
    assign out_pb    = s2_pb;
    assign out_kb    = s2_kb;
    assign out_zb    = s2_zb;

endmodule
